// File: rtl/z80_io_pkg.sv
// Shared definitions for the Z80 I/O bus master.
// Register map, command/status fields and FSM encoding.
package z80_io_pkg;

  localparam logic [31:0] CMD_OFF    = 32'h0;
  localparam logic [31:0] RESULT_OFF = 32'h4;
  localparam logic [31:0] STATUS_OFF = 32'h8;

  localparam int PORT_LSB  = 0;
  localparam int WDATA_LSB = 8;
  localparam int WRITE_BIT = 16;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/z80_cycle_timer.sv
// Loadable down-counter that stops at zero.
// Paces each phase of a Z80 I/O bus cycle.
module z80_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_b,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/z80_io_master.sv
// Wishbone-controlled Z80 IN/OUT cycle generator.
// One command runs one setup/strobe/hold bus cycle.
module z80_io_master
  import z80_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0100,
  parameter int          SETUP_CYCLES  = 2,
  parameter int          STROBE_CYCLES = 8,
  parameter int          HOLD_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  output logic        z80_write_strobe_b,
  output logic        z80_read_strobe_b,
  output logic [7:0]  z80_address_bus,
  output logic [7:0]  z80_data_bus_out,
  input  logic [7:0]  z80_data_bus_in,
  output logic        z80_bus_dir,
  input  logic        wb_cyc_in,
  input  logic        wb_stb_in,
  input  logic        wb_we_in,
  input  logic [31:0] wb_addr_in,
  input  logic [31:0] wb_data_in,
  output logic        wb_ack_out,
  output logic        wb_stall_out,
  output logic [31:0] wb_data_out
);

  localparam int MAXC =
    max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  state_t state, state_n;
  logic          load;
  logic [CW-1:0] load_val;
  logic          zero;

  logic [7:0] sync_data;
  logic [7:0] result;
  logic       is_write;
  logic       done;
  logic       overrun;

  logic        wb_req, hit_cmd, hit_res, hit_sta, hit_any;
  logic        cmd_wr, accept, ovr_set, ovr_clr;
  logic        res_rd, done_set, rdata_cap;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign wb_stall_out = 1'b0;
  assign unused_bits  = ^wb_data_in[31:17];

  assign wb_req  = wb_cyc_in && wb_stb_in;
  assign hit_cmd = wb_req && (wb_addr_in == BASE_ADDRESS + CMD_OFF);
  assign hit_res = wb_req && (wb_addr_in == BASE_ADDRESS + RESULT_OFF);
  assign hit_sta = wb_req && (wb_addr_in == BASE_ADDRESS + STATUS_OFF);
  assign hit_any = hit_cmd || hit_res || hit_sta;

  assign cmd_wr    = hit_cmd && wb_we_in;
  assign accept    = cmd_wr && (state == IDLE);
  assign ovr_set   = cmd_wr && (state != IDLE);
  assign ovr_clr   = hit_sta && wb_we_in && wb_data_in[ST_OVERRUN];
  assign res_rd    = hit_res && !wb_we_in;
  assign done_set  = (state == HOLD) && zero;
  assign rdata_cap = (state == STROBE) && zero && !is_write;

  z80_cycle_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset_b    (reset_b),
    .load       (load),
    .load_value (load_val),
    .zero       (zero)
  );

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    load_val = '0;
    unique case (state)
      IDLE: if (accept) begin
        state_n  = SETUP;
        load     = 1'b1;
        load_val = SETUP_LD;
      end
      SETUP: if (zero) begin
        state_n  = STROBE;
        load     = 1'b1;
        load_val = STROBE_LD;
      end
      STROBE: if (zero) begin
        state_n  = HOLD;
        load     = 1'b1;
        load_val = HOLD_LD;
      end
      HOLD: if (zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_res: rd_mux = {23'b0, done, result};
      hit_sta: rd_mux = {29'b0, overrun, done,
                         (state != IDLE)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state              <= IDLE;
      sync_data          <= '0;
      result             <= '0;
      is_write           <= 1'b0;
      done               <= 1'b0;
      overrun            <= 1'b0;
      z80_write_strobe_b <= 1'b1;
      z80_read_strobe_b  <= 1'b1;
      z80_address_bus    <= '0;
      z80_data_bus_out   <= '0;
      z80_bus_dir        <= 1'b0;
      wb_ack_out         <= 1'b0;
      wb_data_out        <= '0;
    end else begin
      state       <= state_n;
      sync_data   <= z80_data_bus_in;
      wb_ack_out  <= hit_any;
      wb_data_out <= (hit_any && !wb_we_in) ? rd_mux : '0;

      if (accept) begin
        is_write        <= wb_data_in[WRITE_BIT];
        z80_address_bus <= wb_data_in[PORT_LSB +: 8];
        if (wb_data_in[WRITE_BIT])
          z80_data_bus_out <= wb_data_in[WDATA_LSB +: 8];
      end

      // Strobes follow the next state so they stay registered.
      z80_write_strobe_b <= !((state_n == STROBE) && is_write);
      z80_read_strobe_b  <= !((state_n == STROBE) && !is_write);
      z80_bus_dir <= accept ? wb_data_in[WRITE_BIT]
                            : ((state_n != IDLE) && is_write);

      if (rdata_cap) result <= sync_data;

      if (done_set)
        done <= 1'b1;
      else if (accept || res_rd)
        done <= 1'b0;

      if (ovr_set)
        overrun <= 1'b1;
      else if (ovr_clr)
        overrun <= 1'b0;
    end
  end

endmodule
